// File: rtl/ir_pkg.sv
// Shared constants and entry type for the instruction prefetch queue.
package ir_pkg;

  localparam int unsigned IR_W_DEFAULT = 8;

  localparam logic [IR_W_DEFAULT-1:0] IR_NOP = '0;

  typedef struct packed {
    logic                    sf;
    logic [IR_W_DEFAULT-1:0] word;
  } ir_entry_t;

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module ir_queue_mem #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by count, so stale
  // contents are never presented and a reset path would only cost flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Show-ahead queue of instruction words with second-fetch tags, between fetch and decode.
module instr_prefetch_queue
  import ir_pkg::*;
#(
  parameter int unsigned IR_W  = IR_W_DEFAULT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IR_W-1:0]  ir_new,
  input  logic             sf1_in,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IR_W-1:0]  ir,
  output logic             sf1,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic            sf;
    logic [IR_W-1:0] word;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  entry_t           wr_entry, head;

  // in_ready looks only at count, so a pop cannot open a slot in the same cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;

  assign wr_entry = '{sf: sf1_in, word: ir_new};

  ir_queue_mem #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush & ~rst),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    ir  = IR_W'(IR_NOP);
    sf1 = 1'b0;
    if (out_valid) begin
      ir  = head.word;
      sf1 = head.sf;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue (IR_W=8, DEPTH=4).
module tb_instr_prefetch_queue;
  import ir_pkg::*;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, sf1_in, out_ready;
  logic [IR_W-1:0]  ir_new;
  logic             in_ready, out_valid, sf1;
  logic [IR_W-1:0]  ir;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_prefetch_queue #(.IR_W(IR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .ir_new    (ir_new),
    .sf1_in    (sf1_in),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .ir        (ir),
    .sf1       (sf1),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance one clock edge; inputs and checks happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [IR_W-1:0] w, input logic sf);
    in_valid = 1'b1;
    ir_new   = w;
    sf1_in   = sf;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_word();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [IR_W-1:0] model_q[$];
  logic [IR_W-1:0] fill_words [4];

  initial begin
    fill_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; ir_new = 8'hA5; sf1_in = 1'b1; out_ready = 1'b0;

    // Reset held two cycles with a push attempt pending.
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_count",     32'(count),     0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_ir",        32'(ir),        0);
    check("rst_sf1",       32'(sf1),       0);
    check("rst_in_ready",  32'(in_ready),  1);
    step();
    check("rst_no_push",   32'(count),     0);

    // Fill: first push is not visible in its own cycle.
    in_valid = 1'b1; ir_new = 8'h11; sf1_in = 1'b0;
    check("no_bypass_valid", 32'(out_valid), 0);
    check("no_bypass_ir",    32'(ir),        0);
    step();
    check("lat1_ir",    32'(ir),        32'h11);
    check("lat1_valid", 32'(out_valid), 1);
    for (int i = 1; i < 4; i++) push_word(fill_words[i], 1'b0);
    check("full_count",    32'(count),    4);
    check("full_in_ready", 32'(in_ready), 0);
    push_word(8'h55, 1'b0);
    check("ovf_count", 32'(count), 4);
    check("ovf_head",  32'(ir),    32'h11);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_ir%0d", i), 32'(ir),        32'(fill_words[i]));
      check($sformatf("drain_v%0d", i),  32'(out_valid), 1);
      pop_word();
    end
    check("empty_valid", 32'(out_valid), 0);
    check("empty_ir",    32'(ir),        0);
    check("empty_count", 32'(count),     0);
    pop_word();
    check("underflow_count", 32'(count), 0);

    // Tag integrity.
    push_word(8'h81, 1'b1);
    push_word(8'h02, 1'b0);
    check("tag0_ir",  32'(ir),  32'h81);
    check("tag0_sf1", 32'(sf1), 1);
    pop_word();
    check("tag1_ir",  32'(ir),  32'h02);
    check("tag1_sf1", 32'(sf1), 0);
    pop_word();
    check("tag_empty_sf1", 32'(sf1), 0);

    // Concurrent push/pop at count = 2 across several pointer wraps.
    push_word(8'hA0, 1'b0);
    push_word(8'hA1, 1'b0);
    model_q = '{8'hA0, 8'hA1};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; ir_new = 8'hB0 + 8'(i); sf1_in = 1'b0; out_ready = 1'b1;
      check($sformatf("conc_ir%0d", i), 32'(ir), 32'(model_q[0]));
      model_q.push_back(ir_new);
      void'(model_q.pop_front());
      step();
      check($sformatf("conc_cnt%0d", i), 32'(count), 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("conc_tail_ir", 32'(ir), 32'(model_q[0]));

    // Flush mid-stream at count = 3 with push and pop asserted.
    push_word(8'hC0, 1'b1);
    check("pre_flush_count", 32'(count), 3);
    flush = 1'b1; in_valid = 1'b1; ir_new = 8'hDD; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 32'(count),     0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_ir",    32'(ir),        0);
    check("flush_sf1",   32'(sf1),       0);
    push_word(8'hE1, 1'b0);
    check("post_flush_head", 32'(ir),    32'hE1);
    check("post_flush_cnt",  32'(count), 1);

    // Full with simultaneous pop: pop accepted, push rejected.
    push_word(8'hE2, 1'b0);
    push_word(8'hE3, 1'b0);
    push_word(8'hE4, 1'b0);
    check("full2_count", 32'(count), 4);
    in_valid = 1'b1; ir_new = 8'hFF; out_ready = 1'b1;
    check("full2_in_ready", 32'(in_ready), 0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pop_count", 32'(count), 3);
    check("full_pop_ir",    32'(ir),    32'hE2);
    pop_word();
    check("full_pop_ir2", 32'(ir), 32'hE3);
    pop_word();
    check("full_pop_ir3", 32'(ir), 32'hE4);
    pop_word();
    check("full_pop_end", 32'(out_valid), 0);

    // Reset mid-stream drops everything.
    push_word(8'h71, 1'b0);
    push_word(8'h72, 1'b0);
    push_word(8'h73, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_count", 32'(count),     0);
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_ir",    32'(ir),        0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Parametrised successor to the single-stage instruction register: a DEPTH-entry show-ahead queue of instruction words, each tagged with its second-fetch flag (sf).
- Sits between the fetch stage and decode. Decouples fetch from decode stalls.
- Flush empties the queue and presents a NOP to decode, the same as a flushed register.

Parameters:
- IR_W, 8, instruction word width in bits.
- DEPTH, 4, number of queue entries. Power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all queued entries (branch/jump redirect).
- in_valid  in  1  fetch presents a word this cycle.
- ir_new  in  IR_W  fetched instruction word.
- sf1_in  in  1  second-fetch flag accompanying ir_new.
- in_ready  out  1  queue can accept a word; equals (count < DEPTH).
- out_ready  in  1  decode consumes the head entry this cycle.
- out_valid  out  1  head entry is valid; equals (count != 0).
- ir  out  IR_W  head instruction word; IR_NOP when empty.
- sf1  out  1  head second-fetch flag; 0 when empty.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- One clock domain. Reset is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset state:
  - wr_ptr = rd_ptr = 0 and count = 0.
  - out_valid = 0, ir = IR_NOP (0), sf1 = 0, in_ready = 1.
  - Storage contents are don't-care after reset.
- push = in_valid & in_ready.
- pop = out_ready & out_valid.
- Popping an empty queue is ignored. Pushing a full queue is ignored, and no entry is overwritten.
- Show-ahead output:
  - ir and sf1 are combinational from the head entry when count != 0.
  - Otherwise they are forced to IR_NOP and 0.
  - A pushed word is visible at the outputs the cycle after it is pushed. Latency is 1 cycle and there is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: both take effect and count is unchanged.
- Full queue (count == DEPTH):
  - in_ready = 0, so a push is not accepted even if a pop occurs in the same cycle.
  - in_ready does not depend combinationally on out_ready.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH with no special handling. Count is tracked separately, so full and empty are unambiguous.
- Flush:
  - On the next edge: pointers = 0, count = 0.
  - Outputs show NOP/0 with out_valid = 0 from the cycle after flush.
  - Push and pop in the flush cycle are discarded. Flush has priority over push and pop.
- Priority: rst > flush > push/pop.
- Reset or flush mid-stream (for example count = 3) drops all entries. No partial entries survive.
- No state machine beyond the pointers and count. The sf tag travels with its word unchanged.

Decomposition:
- Package ir_pkg holds:
  - IR_W_DEFAULT.
  - IR_NOP (all zeros).
  - a typedef ir_entry_t = {sf, word[IR_W-1:0]}.
- One natural sub-module: ir_queue_mem, a DEPTH x (IR_W+1) register array.
  - Synchronous write at wr_ptr.
  - Asynchronous read at rd_ptr.
  - No reset on storage.
- Pointer, count and flush control live in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid = 1 and ir_new = 8'hA5 -> count = 0, out_valid = 0, ir = 8'h00, sf1 = 0, in_ready = 1 after release.
- Fill and drain:
  - Push 8'h11, 8'h22, 8'h33, 8'h44 with out_ready = 0 -> count = 4, in_ready = 0.
  - A fifth push of 8'h55 is ignored.
  - Pop 4 times -> ir is 11, 22, 33, 44 in order, then NOP with out_valid = 0.
- Tag integrity: push {8'h81, sf = 1} then {8'h02, sf = 0} -> the head shows sf1 = 1 with 8'h81, then sf1 = 0 with 8'h02.
- Concurrent push/pop:
  - With count = 2, push and pop every cycle for 10 cycles -> count stays 2 and the output order matches the input order.
  - Pointers wrap at least twice during the run.
- Flush mid-stream:
  - With count = 3, assert flush together with in_valid = 1 and out_ready = 1 -> the next cycle has count = 0, out_valid = 0, ir = NOP.
  - The word pushed in the flush cycle is absent.
- Full with pop: at count = 4, assert out_ready = 1 and in_valid = 1 -> the pop occurs, the push is rejected (in_ready = 0), and count = 3.
